count_seq_checker: RTL and testbench
====================================

# count_seq_checker

Receive-side checker for the free-running counter stream produced by `clockedlogic`. It samples a count word each valid cycle, acquires lock after a run of consecutive +1 samples, then flywheels an expected value and flags every sample that deviates from it. It sits downstream of any counter source (directly or across a link) and gives a live integrity indication plus error statistics for bring-up and formal/BMC harnesses.

## Interface
- `WIDTH`, 64, width of the count word.
- `LOCK_CNT`, 4, consecutive matching samples required to declare lock (≥2).
- `UNLOCK_ERRS`, 3, consecutive mismatching samples in LOCKED that drop lock (≥1).
- `clk  input  1  sole clock; all state updates on posedge.`
- `rst  input  1  asynchronous, active-high reset.`
- `valid_i  input  1  count_i is sampled this cycle.`
- `count_i  input  WIDTH  count word from the source.`
- `locked  output  1  high while in LOCKED.`
- `error  output  1  one-cycle pulse per mismatching sample while LOCKED.`
- `expected  output  WIDTH  value the next valid sample must carry.`
- `err_cnt  output  16  saturating count of mismatches (stats build only).`
- `last_gap  output  WIDTH  count_i − expected of most recent mismatch, mod 2^WIDTH (stats build only).`

## Operation
- States: SEARCH, ACQUIRE, LOCKED. Reset state SEARCH.
- Nothing changes on cycles with `valid_i`=0; gaps in valid are legal stalls, not errors.
- Match means `count_i == expected`, compared at full WIDTH; arithmetic is modulo 2^WIDTH, so all-ones followed by zero is a match.
- SEARCH, valid: `expected <= count_i+1`, match_cnt ← 1, go ACQUIRE.
- ACQUIRE, valid & match: `expected <= expected+1`, match_cnt++; when match_cnt reaches LOCK_CNT go LOCKED, miss_cnt ← 0.
- ACQUIRE, valid & mismatch: resync `expected <= count_i+1`, match_cnt ← 1, stay ACQUIRE; no error pulse, no err_cnt change.
- LOCKED, valid & match: `expected <= expected+1`, miss_cnt ← 0.
- LOCKED, valid & mismatch: flywheel `expected <= expected+1` (no resync), `error` pulses, err_cnt increments (saturates at 0xFFFF), last_gap captured, miss_cnt++; when miss_cnt reaches UNLOCK_ERRS go SEARCH.
- Every mismatch in LOCKED, including the one that drops lock, produces an error pulse.
- Reset values: `locked`=0, `error`=0, `expected`=0, `err_cnt`=0, `last_gap`=0, match_cnt=0, miss_cnt=0.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- Sample at edge N → `error`, `expected`, `err_cnt`, `last_gap` updated and visible after edge N (one-cycle latency).
- `locked` rises in the cycle after the LOCK_CNT-th consecutive matching sample; falls in the cycle after the UNLOCK_ERRS-th consecutive mismatch.
- `error` is high for exactly one cycle per mismatching sample; back-to-back mismatches give back-to-back pulses.
- `rst` asserted at any time (mid-acquire, mid-error) clears all state immediately, independent of `clk`; first sample after deassertion is treated as in SEARCH.

## Configuration
- `COUNT_SEQ_CHECKER_STATS_EN` defined: err_cnt saturating counter and last_gap capture register are built.
- Not defined: that logic is omitted; `err_cnt` and `last_gap` ports remain and are tied to 0. FSM, `locked`, `error`, `expected` are unchanged.

## Structure
- Package `count_seq_pkg`: state enum (SEARCH, ACQUIRE, LOCKED), `ERR_CNT_W`=16, `ERR_CNT_MAX`.
- One sub-module, `sat_counter` (parameterised width, increment/clear, saturate at max), used for err_cnt; match_cnt and miss_cnt stay inline.

## Test plan
- Reset, then count_i = 100,101,102,103 on consecutive valid cycles → `locked`=1 after the 4th sample, `expected`=104, `error` never high.
- Locked at expected=200, send 200,205,202 → one `error` pulse for 205, `err_cnt`=1, `last_gap`=4, `expected`=203, `locked` stays 1.
- Locked, send three consecutive wrong values → three error pulses, `locked`=0 after the third, state SEARCH, `err_cnt`=3.
- Wrap: lock on 2^64−3, −2, −1, then 0 → `locked`=1, `expected`=1, no error.
- Acquire 10,11,50,51,52,53 with valid gaps between samples → no error, resync at 50, `locked`=1 after 53, `expected`=54.
- Assert `rst` mid-ACQUIRE and mid-LOCKED with err_cnt=5 → all outputs 0 immediately; without STATS_EN, `err_cnt`/`last_gap` stay 0 throughout the mismatch scenarios.

Source files
------------

// File: rtl/count_seq_pkg.sv
// rtl/count_seq_pkg.sv - shared types and constants for count_seq_checker
package count_seq_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    localparam int              ERR_CNT_W   = 16;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = {ERR_CNT_W{1'b1}};

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    // Count up on inc_i, holding at MAX once reached; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (inc_i && (count_q != MAX)) begin
            count_q <= count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/count_seq_checker.sv
// rtl/count_seq_checker.sv - counter-stream lock/flywheel checker; optional stats via COUNT_SEQ_CHECKER_STATS_EN
module count_seq_checker
    import count_seq_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_ERRS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [WIDTH-1:0]     count_i,
    output logic                 locked,
    output logic                 error,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [WIDTH-1:0]     last_gap
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int XW = $clog2(UNLOCK_ERRS + 1);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    MATCH_ONE = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [XW-1:0]    MISS_ONE  = {{(XW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_CNT - 1);
    localparam logic [XW-1:0]    MISS_LAST = XW'(UNLOCK_ERRS - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic [MW-1:0]    match_cnt_q, match_cnt_d;
    logic [XW-1:0]    miss_cnt_q, miss_cnt_d;
    logic             error_q, error_d;
    logic             locked_q;
    logic             match;

    assign match = (count_i == expected_q);

    // Next-state decode; stall cycles (valid_i low) hold everything except the error pulse.
    always_comb begin
        state_d     = state_q;
        expected_d  = expected_q;
        match_cnt_d = match_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        error_d     = 1'b0;
        if (valid_i) begin
            case (state_q)
                ST_SEARCH: begin
                    expected_d  = count_i + ONE;
                    match_cnt_d = MATCH_ONE;
                    state_d     = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (match) begin
                        expected_d  = expected_q + ONE;
                        match_cnt_d = match_cnt_q + MATCH_ONE;
                        if (match_cnt_q == LOCK_LAST) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        // Resync silently: acquisition misses are not errors.
                        expected_d  = count_i + ONE;
                        match_cnt_d = MATCH_ONE;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: expected advances whether or not the sample matched.
                    expected_d = expected_q + ONE;
                    if (match) begin
                        miss_cnt_d = '0;
                    end else begin
                        error_d = 1'b1;
                        if (miss_cnt_q == MISS_LAST) begin
                            state_d     = ST_SEARCH;
                            miss_cnt_d  = '0;
                            match_cnt_d = '0;
                        end else begin
                            miss_cnt_d = miss_cnt_q + MISS_ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_SEARCH;
                end
            endcase
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            expected_q  <= '0;
            match_cnt_q <= '0;
            miss_cnt_q  <= '0;
            error_q     <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            match_cnt_q <= match_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            error_q     <= error_d;
            locked_q    <= (state_d == ST_LOCKED);
        end
    end

    assign locked   = locked_q;
    assign error    = error_q;
    assign expected = expected_q;

`ifdef COUNT_SEQ_CHECKER_STATS_EN
    logic [WIDTH-1:0] last_gap_q;

    sat_counter #(
        .WIDTH (ERR_CNT_W),
        .MAX   (ERR_CNT_MAX)
    ) u_err_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (1'b0),
        .inc_i   (error_d),
        .count_o (err_cnt)
    );

    // Capture how far off the most recent locked mismatch was.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gap_q <= '0;
        end else if (error_d) begin
            last_gap_q <= count_i - expected_q;
        end
    end

    assign last_gap = last_gap_q;
`else
    assign err_cnt  = '0;
    assign last_gap = '0;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// tb/tb_count_seq_checker.sv - randomized self-checking bench for count_seq_checker
module tb_count_seq_checker;

    localparam int LOCK_CNT    = 4;
    localparam int UNLOCK_ERRS = 3;
`ifdef COUNT_SEQ_CHECKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [63:0] count_i;
    logic        locked;
    logic        error;
    logic [63:0] expected;
    logic [15:0] err_cnt;
    logic [63:0] last_gap;

    int n_cmp;
    int n_bad;

    // Reference model: tracks the current run of consecutive +1 samples and
    // the lock / miss history directly from the stream semantics.
    bit          m_locked;
    bit          m_have;
    bit          m_err;
    int          m_run;
    int          m_miss;
    int          m_errs;
    logic [63:0] m_exp;
    logic [63:0] m_gap;

    count_seq_checker #(
        .WIDTH       (64),
        .LOCK_CNT    (LOCK_CNT),
        .UNLOCK_ERRS (UNLOCK_ERRS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .count_i  (count_i),
        .locked   (locked),
        .error    (error),
        .expected (expected),
        .err_cnt  (err_cnt),
        .last_gap (last_gap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_have = 0; m_err = 0; m_run = 0; m_miss = 0;
        m_errs = 0; m_exp = '0; m_gap = '0;
    endtask

    task automatic model_sample(input logic [63:0] v);
        if (!m_locked) begin
            if (m_have && v == m_exp) m_run++;
            else m_run = 1;
            m_have = 1;
            m_exp  = v + 64'd1;
            if (m_run == LOCK_CNT) begin
                m_locked = 1;
                m_miss   = 0;
            end
        end else begin
            if (v == m_exp) begin
                m_miss = 0;
            end else begin
                m_err = 1;
                if (m_errs < 65535) m_errs++;
                m_gap = v - m_exp;
                m_miss++;
            end
            m_exp = m_exp + 64'd1;
            if (m_miss == UNLOCK_ERRS) begin
                m_locked = 0;
                m_have   = 0;
                m_miss   = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".locked"},   {63'd0, locked},   {63'd0, m_locked});
        check({tag, ".error"},    {63'd0, error},    {63'd0, m_err});
        check({tag, ".expected"}, expected,          m_exp);
        check({tag, ".err_cnt"},  {48'd0, err_cnt},  STATS ? 64'(m_errs) : 64'd0);
        check({tag, ".last_gap"}, last_gap,          STATS ? m_gap : 64'd0);
    endtask

    task automatic step(input string tag, input bit v, input logic [63:0] c);
        @(negedge clk);
        valid_i = v;
        count_i = c;
        @(posedge clk);
        #1;
        m_err = 0;
        if (v) model_sample(c);
        check_all(tag);
    endtask

    // Asynchronous reset pulse landing between clock edges.
    task automatic async_reset(input string tag);
        @(negedge clk);
        valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [63:0] src;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; valid_i = 1'b0; count_i = '0;
        model_reset();
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Basic lock.
        for (int i = 0; i < 4; i++) step("lock", 1'b1, 64'd100 + 64'(i));
        check("lock.const_locked", {63'd0, locked}, 64'd1);
        check("lock.const_expected", expected, 64'd104);

        // Single mismatch while locked.
        async_reset("rst1");
        for (int i = 0; i < 4; i++) step("pre200", 1'b1, 64'd196 + 64'(i));
        step("s200", 1'b1, 64'd200);
        step("s205", 1'b1, 64'd205);
        check("s205.const_error", {63'd0, error}, 64'd1);
        step("s202", 1'b1, 64'd202);
        check("s202.const_expected", expected, 64'd203);
        check("s202.const_last_gap", last_gap, STATS ? 64'd4 : 64'd0);
        check("s202.const_locked", {63'd0, locked}, 64'd1);

        // Three consecutive misses drop lock.
        async_reset("rst2");
        for (int i = 0; i < 4; i++) step("pre_drop", 1'b1, 64'd500 + 64'(i));
        for (int i = 0; i < 3; i++) step("drop", 1'b1, 64'd9000 + 64'(i * 7));
        check("drop.const_locked", {63'd0, locked}, 64'd0);
        check("drop.const_err_cnt", {48'd0, err_cnt}, STATS ? 64'd3 : 64'd0);
        step("after_drop", 1'b1, 64'd77);

        // Wrap through all-ones.
        async_reset("rst3");
        for (int i = 3; i >= 0; i--) step("wrap", 1'b1, 64'd0 - 64'(i));
        check("wrap.const_expected", expected, 64'd1);
        check("wrap.const_locked", {63'd0, locked}, 64'd1);

        // Resync during acquire with valid gaps.
        async_reset("rst4");
        step("gap_a", 1'b1, 64'd10);
        step("gap_s", 1'b0, 64'd999);
        step("gap_b", 1'b1, 64'd11);
        step("gap_s", 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step("gap_c", 1'b1, 64'd50 + 64'(i));
            step("gap_s", 1'b0, 64'd12345);
        end
        check("gap.const_expected", expected, 64'd54);

        // Reset mid-acquire, then mid-locked with five errors.
        async_reset("rst5");
        step("macq", 1'b1, 64'd1000);
        step("macq", 1'b1, 64'd1001);
        async_reset("rst_macq");
        for (int i = 0; i < 4; i++) step("mlk", 1'b1, 64'd2000 + 64'(i));
        step("mlk_e", 1'b1, 64'd1);
        step("mlk_e", 1'b1, 64'd2);
        step("mlk_m", 1'b1, 64'd2006);
        step("mlk_e", 1'b1, 64'd3);
        step("mlk_e", 1'b1, 64'd4);
        step("mlk_m", 1'b1, 64'd2009);
        step("mlk_e", 1'b1, 64'd5);
        check("mlk.const_err_cnt", {48'd0, err_cnt}, STATS ? 64'd5 : 64'd0);
        async_reset("rst_mlk");

        // Randomized stream: stalls, single-bit corruptions, bursts, jumps.
        src = {$urandom, $urandom};
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 20) begin
                step("rnd_stall", 1'b0, {$urandom, $urandom});
            end else if (r < 28) begin
                step("rnd_bad", 1'b1, src ^ (64'd1 << $urandom_range(0, 63)));
                src = src + 64'd1;
            end else if (r < 30) begin
                src = {$urandom, $urandom};
                step("rnd_jump", 1'b1, src);
                src = src + 64'd1;
            end else if (r == 30) begin
                async_reset("rnd_rst");
            end else begin
                step("rnd_ok", 1'b1, src);
                src = src + 64'd1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
